// File: rtl/dot_product_issuer.sv
// Packs (data, weight) pairs into LANES-wide vectors for a fixed-latency summation pipe.
// Sums come back into a credit-protected result FIFO and leave on a valid/ready stream.
module dot_product_issuer #(
    parameter int WIDTH     = 16,
    parameter int LANES     = 4,
    parameter int PIPE_LAT  = 2,
    parameter int RES_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [WIDTH-1:0]             in_data_i,
    input  logic [WIDTH-1:0]             in_weight_i,
    output logic [LANES-1:0][WIDTH-1:0]  pe_data_o,
    output logic [LANES-1:0][WIDTH-1:0]  pe_weights_o,
    input  logic [WIDTH-1:0]             pe_result_i,
    output logic                         res_valid_o,
    input  logic                         res_ready_i,
    output logic [WIDTH-1:0]             res_data_o,
    output logic                         busy_o
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam int RSV_W = $clog2(RES_DEPTH + PIPE_LAT + 2);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_ISSUE   = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [LANES-1:0][WIDTH-1:0]     stg_data_q, stg_data_d;
    logic [LANES-1:0][WIDTH-1:0]     stg_wt_q, stg_wt_d;
    logic [LANES-1:0][WIDTH-1:0]     pe_data_q, pe_data_d;
    logic [LANES-1:0][WIDTH-1:0]     pe_wt_q, pe_wt_d;
    logic [PIPE_LAT-1:0]             tag_q, tag_d;
    logic [RES_DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;

    logic                            in_ready_s;
    logic                            push_s;
    logic                            pop_s;
    logic [RSV_W-1:0]                tag_cnt_s;
    logic [RSV_W-1:0]                reserved_s;

    // Next-state logic: collection FSM, tag shift, credit check and result FIFO.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        stg_data_d = stg_data_q;
        stg_wt_d   = stg_wt_q;
        pe_data_d  = pe_data_q;
        pe_wt_d    = pe_wt_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        in_ready_s = 1'b0;

        tag_cnt_s = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            tag_cnt_s = tag_cnt_s + RSV_W'(tag_q[i]);
        end
        // Every issued vector owns a FIFO slot until its result is popped.
        reserved_s = RSV_W'(cnt_q) + tag_cnt_s + RSV_W'(state_q == ST_ISSUE);

        case (state_q)
            ST_COLLECT: begin
                in_ready_s = (idx_q != '0) || (reserved_s < RSV_W'(RES_DEPTH));
                if (in_valid_i && in_ready_s) begin
                    stg_data_d[idx_q] = in_data_i;
                    stg_wt_d[idx_q]   = in_weight_i;
                    if (idx_q == IDX_W'(LANES - 1)) begin
                        // Load pe_* with the final lane bypassed so the vector shows during ISSUE.
                        idx_d     = '0;
                        state_d   = ST_ISSUE;
                        pe_data_d = stg_data_d;
                        pe_wt_d   = stg_wt_d;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_ISSUE: begin
                state_d = ST_COLLECT;
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        tag_d[0] = (state_q == ST_ISSUE);
        for (int i = 1; i < PIPE_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        push_s = tag_q[PIPE_LAT-1];
        pop_s  = (cnt_q != '0) && res_ready_i;
        if (push_s) begin
            mem_d[wr_ptr_q] = pe_result_i;
            wr_ptr_d = (wr_ptr_q == PTR_W'(RES_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(RES_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        cnt_d = cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // State registers with synchronous reset; reset discards partial vectors, tags and FIFO data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_COLLECT;
            idx_q      <= '0;
            stg_data_q <= '0;
            stg_wt_q   <= '0;
            pe_data_q  <= '0;
            pe_wt_q    <= '0;
            tag_q      <= '0;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            stg_data_q <= stg_data_d;
            stg_wt_q   <= stg_wt_d;
            pe_data_q  <= pe_data_d;
            pe_wt_q    <= pe_wt_d;
            tag_q      <= tag_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready_o   = in_ready_s;
    assign pe_data_o    = pe_data_q;
    assign pe_weights_o = pe_wt_q;
    assign res_valid_o  = (cnt_q != '0);
    assign res_data_o   = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign busy_o       = (idx_q != '0) || (state_q == ST_ISSUE) || (tag_q != '0) || (cnt_q != '0);

endmodule

// File: tb/tb_dot_product_issuer.sv
// Bench for dot_product_issuer with a behavioural two-stage summation pipe.
// Expected sums come from a pair-level model: every LANES accepted pairs give sum(d*w) mod 2^16.
module tb_dot_product_issuer;

    localparam int W  = 16;
    localparam int L  = 4;
    localparam int PL = 2;
    localparam int D  = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [W-1:0]         in_data = '0;
    logic [W-1:0]         in_weight = '0;
    logic [L-1:0][W-1:0]  pe_data;
    logic [L-1:0][W-1:0]  pe_weights;
    logic [W-1:0]         pe_result;
    logic                 res_valid;
    logic                 res_ready = 1'b1;
    logic [W-1:0]         res_data;
    logic                 busy;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] pend_d[$];
    logic [W-1:0] pend_w[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] last_q[$];

    dot_product_issuer #(.WIDTH(W), .LANES(L), .PIPE_LAT(PL), .RES_DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_weight_i(in_weight), .pe_data_o(pe_data),
        .pe_weights_o(pe_weights), .pe_result_i(pe_result), .res_valid_o(res_valid),
        .res_ready_i(res_ready), .res_data_o(res_data), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] dot(input logic [L-1:0][W-1:0] a, input logic [L-1:0][W-1:0] b);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < L; i++) s = s + 32'(a[i]) * 32'(b[i]);
        return s[W-1:0];
    endfunction

    // Free-running summation pipe: vector on pe_* in cycle N gives its sum in cycle N+PL.
    logic [W-1:0] pipe_q [PL];
    always @(posedge clk) begin
        pipe_q[0] <= dot(pe_data, pe_weights);
        for (int i = 1; i < PL; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign pe_result = pipe_q[PL-1];

    always @(posedge clk) begin
        if (!rst && res_valid && res_ready) got_q.push_back(res_data);
    end

    always @(posedge clk) begin
        if (!rst && dut.tag_q[PL-1] && (dut.cnt_q == 3'(D))) begin
            failures++;
            $display("FAIL fifo_overflow push while full at %0t", $time);
        end
    end

    function automatic void model_accept(input logic [W-1:0] d, input logic [W-1:0] w);
        logic [31:0] s;
        pend_d.push_back(d);
        pend_w.push_back(w);
        if (pend_d.size() == L) begin
            s = 32'd0;
            for (int i = 0; i < L; i++) s = s + 32'(pend_d[i]) * 32'(pend_w[i]);
            exp_q.push_back(s[W-1:0]);
            pend_d.delete();
            pend_w.delete();
        end
    endfunction

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_pair(input logic [W-1:0] d, input logic [W-1:0] w);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_weight = w;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(d, w);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        res_ready = 1'b1;
        while (got_q.size() < exp_q.size() && n < 300) begin @(negedge clk); n++; end
        idle(1);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL result_count got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL result[%0d] got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_drain got=%b required=0", busy);
        end
        last_q = got_q;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pend_d.delete(); pend_w.delete(); exp_q.delete(); got_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 16'h0000 || busy !== 1'b0 ||
            pe_data !== 64'h0 || pe_weights !== 64'h0) begin
            failures++;
            $display("FAIL %s rdy=%b rv=%b rd=%h busy=%b pe=%h/%h required 1,0,0000,0,0/0",
                     tag, in_ready, res_valid, res_data, busy, pe_data, pe_weights);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        check_reset_outputs("reset_state");
    endtask

    task automatic test_single();
        logic [W-1:0] dv [4];
        logic [W-1:0] wv [4];
        int k;
        dv = '{16'd1, 16'd2, 16'd3, 16'd4};
        wv = '{16'd12, 16'd6, 16'd4, 16'd3};
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_pair(dv[i], wv[i]);
        k = 1;
        while (!res_valid && k < 20) begin @(negedge clk); k++; end
        checks++;
        if (k !== 4) begin
            failures++;
            $display("FAIL single_latency got=%0d required=4", k);
        end
        checks++;
        if (res_data !== 16'd48) begin
            failures++;
            $display("FAIL single_sum got=%0d required=48", res_data);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] dv [16];
        logic [W-1:0] wv [16];
        logic [W-1:0] want [4];
        dv = '{16'd1,16'd2,16'd3,16'd4, 16'd2,16'd2,16'd2,16'd2, 16'd1,16'd1,16'd1,16'd1, 16'd0,16'd0,16'd5,16'd3};
        wv = '{16'd12,16'd6,16'd4,16'd3, 16'd5,16'd5,16'd5,16'd5, 16'd2,16'd5,16'd7,16'd9, 16'd13,16'd5,16'd5,16'd4};
        want = '{16'd48, 16'd40, 16'd23, 16'd37};
        res_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_pair(dv[i], wv[i]);
        drain();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (last_q.size() <= i || last_q[i] !== want[i]) begin
                failures++;
                $display("FAIL b2b_literal[%0d] got=%h required=%0d", i,
                         (last_q.size() > i) ? last_q[i] : 16'hxxxx, want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] vd [24];
        logic [W-1:0] vw [24];
        int seen_ready;
        for (int i = 0; i < 24; i++) begin
            vd[i] = 16'($urandom);
            vw[i] = 16'($urandom);
        end
        res_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_pair(vd[i], vw[i]);
        idle(6);
        checks++;
        if (dut.cnt_q !== 3'd4 || res_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_buffered cnt=%0d rv=%b required 4,1", dut.cnt_q, res_valid);
        end
        in_valid = 1'b1; in_data = vd[16]; in_weight = vw[16];
        seen_ready = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (in_ready) seen_ready++;
        end
        checks++;
        if (seen_ready !== 0) begin
            failures++;
            $display("FAIL bp_in_ready_low got=%0d ready cycles required=0", seen_ready);
        end
        res_ready = 1'b1;
        for (int i = 16; i < 24; i++) send_pair(vd[i], vw[i]);
        drain();
    endtask

    task automatic test_push_pop();
        res_ready = 1'b0;
        for (int v = 0; v < 3; v++) begin
            if (v == 2) begin
                for (int i = 0; i < 4; i++) send_pair(16'(v + i + 1), 16'(i + 3));
            end else begin
                for (int i = 0; i < 4; i++) send_pair(16'($urandom), 16'($urandom));
            end
            if (v == 1) begin
                idle(6);
                checks++;
                if (dut.cnt_q !== 3'd2) begin
                    failures++;
                    $display("FAIL pp_pre_count got=%0d required=2", dut.cnt_q);
                end
            end
        end
        @(negedge clk);
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (dut.cnt_q !== 3'd2 || got_q.size() !== 1) begin
            failures++;
            $display("FAIL pp_count cnt=%0d popped=%0d required 2,1", dut.cnt_q, got_q.size());
        end
        drain();
    endtask

    task automatic test_mid_reset();
        res_ready = 1'b1;
        send_pair(16'd7, 16'd7);
        send_pair(16'd9, 16'd9);
        do_reset();
        check_reset_outputs("reset_partial");
        for (int i = 0; i < 4; i++) send_pair(16'd100, 16'd3);
        @(negedge clk);
        do_reset();
        check_reset_outputs("reset_inflight");
        idle(8);
        checks++;
        if (got_q.size() !== 0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_result got=%0d results rv=%b required 0,0", got_q.size(), res_valid);
        end
        for (int i = 0; i < 4; i++) send_pair(16'(i + 2), 16'(i + 5));
        drain();
    endtask

    task automatic test_wrap_gaps();
        logic [W-1:0] wd [4];
        logic [W-1:0] ww [4];
        wd = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        ww = '{16'h0002, 16'h0000, 16'h0000, 16'h0000};
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_pair(wd[i], ww[i]);
            idle(i + 1);
        end
        drain();
        checks++;
        if (last_q.size() != 1 || last_q[0] !== 16'hFFFE) begin
            failures++;
            $display("FAIL wrap_sum got=%h required=fffe", (last_q.size() > 0) ? last_q[0] : 16'hxxxx);
        end
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        fork
            begin
                for (int v = 0; v < 10; v++) begin
                    for (int l = 0; l < L; l++) begin
                        idle($urandom_range(0, 2));
                        send_pair(16'($urandom), 16'($urandom));
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    res_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_push_pop();
        test_mid_reset();
        test_wrap_gaps();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
